inst_feeder: RTL and testbench
==============================

# inst_feeder

Synthesizable instruction issuer that drives the processor's instruction handshake from the initiator side. It holds a loadable instruction ROM, presents one 32-bit instruction per `in_valid` pulse, then waits for the processor's `out_valid` / `inst_addr` completion and uses the returned byte address as the next fetch PC. It sits between a program loader and the processor core's `in_valid`/`inst`/`out_valid`/`inst_addr` ports, replacing the behavioural pattern driver in on-chip self-test builds.

## Interface
Parameters:
- `ADDR_W`, 10: ROM word-address width; depth = 2^ADDR_W words.
- `MAX_WAIT`, 1024: cycles allowed in WAIT before a timeout error.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_en`  in  1  ROM write strobe; honoured only in IDLE.
- `load_addr`  in  ADDR_W  ROM word address to write.
- `load_data`  in  32  instruction word to write.
- `prog_len`  in  ADDR_W+1  program length in words; sampled on `start`.
- `start`  in  1  begin issuing from PC 0; honoured only in IDLE.
- `in_valid`  out  1  one-cycle pulse: `inst` is valid.
- `inst`  out  32  instruction word, registered.
- `out_valid`  in  1  processor completion pulse.
- `inst_addr`  in  32  next-PC byte address, valid with `out_valid`.
- `busy`  out  1  high in ISSUE or WAIT.
- `done`  out  1  sticky; program ran to completion.
- `err`  out  1  sticky; protocol error.
- `err_code`  out  2  0 none, 1 timeout, 2 misaligned `inst_addr`, 3 spurious `out_valid`.
- `issued_cnt`  out  32  instructions issued since `start`.
- `cycle_cnt`  out  32  cycles from `start` to DONE/ERR (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE, ERR.
- IDLE: `load_en` writes `rom[load_addr] <= load_data`. `start` latches `prog_len` into `len_q`, clears counters, sets PC=0; goes to DONE if `prog_len`==0, else to ISSUE. If `start` and `load_en` occur together, the write happens and start is accepted.
- ISSUE (exactly one cycle): `in_valid`=1, `inst`=rom[PC>>2], `issued_cnt`+1; goes to WAIT.
- WAIT: wait counter increments each cycle. On `out_valid`:
  - `inst_addr[1:0]`!=0 -> ERR, code 2.
  - `inst_addr` >= 4*`len_q` -> DONE.
  - otherwise PC=`inst_addr` -> ISSUE.
- WAIT timeout: reaching `MAX_WAIT` cycles without `out_valid` -> ERR, code 1.
- `out_valid` seen in IDLE-after-start, ISSUE or DONE -> ERR, code 3. Priority: code 3 over others.
- DONE/ERR: `in_valid` held 0, flags sticky; leave only via `rst`. `start` and `load_en` are ignored outside IDLE.
- ROM address uses `inst_addr[ADDR_W+1:2]`; upper bits are ignored beyond the length check.
- Counters are 32 bits and wrap modulo 2^32.

## Timing
- Reset (sync, `rst`=1 at an edge): state IDLE; `in_valid`, `inst`, `busy`, `done`, `err`, `err_code`, `issued_cnt`, `cycle_cnt` all 0. ROM contents are preserved. Reset mid-program drops the in-flight instruction with no error.
- `start` sampled at edge t -> `in_valid` high during cycle t+1.
- `out_valid` sampled at edge t -> next `in_valid` high during cycle t+1 (1-cycle turnaround). `in_valid` never asserts two consecutive cycles.
- `done`/`err` rise in the cycle after the deciding `out_valid` or timeout edge.
- ROM write at edge t is readable by an ISSUE in cycle t+1.

## Configuration
- `INST_FEEDER_PERF_EN` defined: `cycle_cnt` increments every cycle in ISSUE and WAIT and freezes in DONE/ERR.
- Not defined: `cycle_cnt` is tied to 0 and no counter is synthesized. `issued_cnt` is unaffected.

## Test plan
- Load 3 words (0xA, 0xB, 0xC); `start`, `prog_len`=3; processor returns 4, 8, 12 one cycle after each `in_valid` -> `inst` sequence 0xA, 0xB, 0xC; `done`=1; `issued_cnt`=3; `cycle_cnt`=6 with macro, 0 without.
- Branch: `prog_len`=4; returns 4, then 0, then 16 -> issues words 0, 1, 0; then `done`=1, `issued_cnt`=3.
- No response: the processor never asserts `out_valid` -> after exactly `MAX_WAIT` WAIT cycles, `err`=1, `err_code`=1, `in_valid` stays 0.
- Misaligned: returns `inst_addr`=0x6 -> `err_code`=2. Separately, `out_valid` during the ISSUE cycle -> `err_code`=3.
- `start` with `prog_len`=0 -> `done`=1 one cycle later, no `in_valid` pulse. `start` while `busy` -> ignored.
- Mid-program: `rst` pulse in WAIT -> all outputs 0 next cycle. Re-`start` -> issues rom[0] unchanged (ROM retained).

Source files
------------

// File: rtl/inst_feeder.sv
// Instruction issuer: replays a loadable ROM into the core's in_valid/inst port and follows the returned next-PC.
// Latency: start or out_valid at edge t gives in_valid in cycle t+1. Flow control: one outstanding instruction; WAIT holds until out_valid or MAX_WAIT.
// Optional `INST_FEEDER_PERF_EN` adds a busy-cycle counter on cycle_cnt; otherwise cycle_cnt is 0.
module inst_feeder #(
   parameter int ADDR_W   = 10,
   parameter int MAX_WAIT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              start,
   output logic              in_valid,
   output logic [31:0]       inst,
   input  logic              out_valid,
   input  logic [31:0]       inst_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [31:0]       issued_cnt,
   output logic [31:0]       cycle_cnt
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int WCW   = $clog2(MAX_WAIT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       rom [DEPTH];
   logic [ADDR_W:0]   len_q, len_d;
   logic [31:0]       inst_q, inst_d;
   logic [31:0]       issued_q, issued_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        code_q, code_d;
   logic [WCW-1:0]    wait_q, wait_d;
   logic [ADDR_W-1:0] rd_idx;
   logic [31:0]       rd_word;
   logic [31:0]       limit;
   logic              load_ok;

   assign load_ok = (state_q == S_IDLE) && load_en;
   assign limit   = 32'(len_q) << 2;

   // The next PC is either 0 (start) or the returned inst_addr, so no PC register is kept.
   // A same-cycle ROM write is forwarded so start+load_en issues the new word.
   always_comb begin
      rd_idx  = (state_q == S_IDLE) ? '0 : inst_addr[ADDR_W+1:2];
      rd_word = rom[rd_idx];
      if (load_ok && (load_addr == rd_idx)) begin
         rd_word = load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (load_ok && !rst) begin
         rom[load_addr] <= load_data;
      end
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      inst_d   = inst_q;
      issued_d = issued_q;
      done_d   = done_q;
      err_d    = err_q;
      code_d   = code_q;
      wait_d   = wait_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d    = prog_len;
               issued_d = '0;
               if (out_valid) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
                  code_d  = 2'd3;
               end else if (prog_len == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  inst_d  = rd_word;
               end
            end
         end
         S_ISSUE: begin
            issued_d = issued_q + 32'd1;
            wait_d   = '0;
            if (out_valid) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               code_d  = 2'd3;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (out_valid) begin
               if (inst_addr[1:0] != 2'b00) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
                  code_d  = 2'd2;
               end else if (inst_addr >= limit) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  inst_d  = rd_word;
               end
            end else if (wait_q == WCW'(MAX_WAIT - 1)) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               code_d  = 2'd1;
            end else begin
               wait_d = wait_q + WCW'(1);
            end
         end
         S_DONE: begin
            if (out_valid) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               code_d  = 2'd3;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         inst_q   <= '0;
         issued_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= 2'd0;
         wait_q   <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         inst_q   <= inst_d;
         issued_q <= issued_d;
         done_q   <= done_d;
         err_q    <= err_d;
         code_q   <= code_d;
         wait_q   <= wait_d;
      end
   end

   assign in_valid   = (state_q == S_ISSUE);
   assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign inst       = inst_q;
   assign done       = done_q;
   assign err        = err_q;
   assign err_code   = code_q;
   assign issued_cnt = issued_q;

`ifdef INST_FEEDER_PERF_EN
   logic [31:0] cyc_q, cyc_d;

   always_comb begin
      cyc_d = cyc_q;
      if ((state_q == S_IDLE) && start) begin
         cyc_d = '0;
      end else if (busy) begin
         cyc_d = cyc_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= '0;
      end else begin
         cyc_q <= cyc_d;
      end
   end

   assign cycle_cnt = cyc_q;
`else
   assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_feeder.sv
// Directed bench for inst_feeder: a queue of expected fetch PCs, derived from the driven responses, checks every issued word.
module tb_inst_feeder;
   localparam int AW = 10;
   localparam int MW = 20;

`ifdef INST_FEEDER_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [31:0]   load_data = '0;
   logic [AW:0]   prog_len = '0;
   logic          start = 1'b0;
   logic          in_valid;
   logic [31:0]   inst;
   logic          out_valid = 1'b0;
   logic [31:0]   inst_addr = '0;
   logic          busy, done, err;
   logic [1:0]    err_code;
   logic [31:0]   issued_cnt, cycle_cnt;

   always #5 clk = ~clk;

   inst_feeder #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .prog_len(prog_len), .start(start),
      .in_valid(in_valid), .inst(inst), .out_valid(out_valid),
      .inst_addr(inst_addr), .busy(busy), .done(done), .err(err),
      .err_code(err_code), .issued_cnt(issued_cnt), .cycle_cnt(cycle_cnt)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] model_rom [1 << AW];
   logic [31:0] exp_q [$];
   int          mlen = 0;
   int          pulses = 0;
   logic        prev_iv = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] cyc(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   // Per-cycle model comparison: each in_valid must match the oldest expected PC.
   always @(negedge clk) begin
      logic [31:0] pc;
      if (rst) begin
         prev_iv = 1'b0;
      end else begin
         check("issued_cnt", issued_cnt, 32'(pulses));
`ifndef INST_FEEDER_PERF_EN
         check("cycle_cnt_off", cycle_cnt, 32'd0);
`endif
         check("busy_vs_flags", {31'b0, busy & (done | err)}, 32'd0);
         if (exp_q.size() == 0) begin
            check("spurious_in_valid", {31'b0, in_valid}, 32'd0);
         end else if (in_valid) begin
            pc = exp_q.pop_front();
            check("inst_word", inst, model_rom[pc[AW+1:2]]);
            check("in_valid_b2b", {31'b0, prev_iv}, 32'd0);
            check("busy_in_issue", {31'b0, busy}, 32'd1);
            pulses++;
         end
         prev_iv = in_valid;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      pulses = 0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic load(input int a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a[AW-1:0];
      load_data = d;
      model_rom[a[AW-1:0]] = d;
      tick();
      load_en = 1'b0;
   endtask

   task automatic do_start(input int len);
      start    = 1'b1;
      prog_len = len[AW:0];
      exp_q.delete();
      pulses = 0;
      mlen   = len;
      if (len != 0) exp_q.push_back(32'd0);
      tick();
      start = 1'b0;
   endtask

   // Waits gap cycles, then pulses out_valid with the next-PC for one cycle.
   task automatic respond(input logic [31:0] a, input int gap);
      repeat (gap) tick();
      out_valid = 1'b1;
      inst_addr = a;
      if ((a[1:0] == 2'b00) && (a < 32'(4 * mlen))) exp_q.push_back(a);
      tick();
      out_valid = 1'b0;
   endtask

   task automatic check_flags(input string tag, input logic d, input logic e, input logic [1:0] c);
      check({tag, "_done"}, {31'b0, done}, {31'b0, d});
      check({tag, "_err"}, {31'b0, err}, {31'b0, e});
      check({tag, "_code"}, {30'b0, err_code}, {30'b0, c});
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) model_rom[i] = '0;
      do_reset();
      check("rst_in_valid", {31'b0, in_valid}, 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check_flags("rst", 1'b0, 1'b0, 2'd0);
      check("rst_issued", issued_cnt, 32'd0);
      check("rst_cycle", cycle_cnt, 32'd0);

      // Straight-line program of three words
      load(0, 32'hA);
      load(1, 32'hB);
      load(2, 32'hC);
      do_start(3);
      check("s1_start_iv", {31'b0, in_valid}, 32'd1);
      check("s1_inst0", inst, 32'hA);
      respond(32'd4, 1);
      check("s1_turn1", {31'b0, in_valid}, 32'd1);
      check("s1_inst1", inst, 32'hB);
      respond(32'd8, 1);
      check("s1_inst2", inst, 32'hC);
      respond(32'd12, 1);
      check_flags("s1", 1'b1, 1'b0, 2'd0);
      check("s1_issued", issued_cnt, 32'd3);
      check("s1_cycle", cycle_cnt, cyc(6));
      out_valid = 1'b1;
      inst_addr = 32'd0;
      tick();
      out_valid = 1'b0;
      check_flags("s1_late_ov", 1'b1, 1'b1, 2'd3);

      // Branch back to word 0
      do_reset();
      load(3, 32'hD);
      do_start(4);
      check("s2_inst0", inst, 32'hA);
      respond(32'd4, 1);
      check("s2_inst1", inst, 32'hB);
      respond(32'd0, 1);
      check("s2_inst2", inst, 32'hA);
      respond(32'd16, 1);
      check_flags("s2", 1'b1, 1'b0, 2'd0);
      check("s2_issued", issued_cnt, 32'd3);
      check("s2_cycle", cycle_cnt, cyc(6));

      // Timeout after exactly MW wait cycles
      do_reset();
      do_start(2);
      repeat (MW) tick();
      check("s3_still_wait", {31'b0, busy}, 32'd1);
      check("s3_no_err_yet", {31'b0, err}, 32'd0);
      tick();
      check_flags("s3", 1'b0, 1'b1, 2'd1);
      check("s3_in_valid", {31'b0, in_valid}, 32'd0);
      check("s3_cycle", cycle_cnt, cyc(1 + MW));

      // Misaligned next-PC
      do_reset();
      do_start(4);
      respond(32'h6, 1);
      check_flags("s4a", 1'b0, 1'b1, 2'd2);
      check("s4a_issued", issued_cnt, 32'd1);

      // out_valid during the ISSUE cycle
      do_reset();
      do_start(4);
      out_valid = 1'b1;
      inst_addr = 32'd4;
      tick();
      out_valid = 1'b0;
      check_flags("s4b", 1'b0, 1'b1, 2'd3);

      // Zero-length program
      do_reset();
      do_start(0);
      check_flags("s5a", 1'b1, 1'b0, 2'd0);
      check("s5a_busy", {31'b0, busy}, 32'd0);

      // start and load_en while busy are ignored
      do_reset();
      do_start(2);
      tick();
      start     = 1'b1;
      prog_len  = '0;
      load_en   = 1'b1;
      load_addr = '0;
      load_data = 32'hBAD;
      tick();
      start   = 1'b0;
      load_en = 1'b0;
      check("s5b_busy", {31'b0, busy}, 32'd1);
      check("s5b_done", {31'b0, done}, 32'd0);
      respond(32'd4, 0);
      respond(32'd8, 1);
      check_flags("s5b", 1'b1, 1'b0, 2'd0);
      check("s5b_issued", issued_cnt, 32'd2);
      check("s5b_cycle", cycle_cnt, cyc(5));

      // Reset mid-program, then restart from the retained ROM
      do_reset();
      do_start(3);
      tick();
      rst = 1'b1;
      exp_q.delete();
      pulses = 0;
      tick();
      rst = 1'b0;
      check("s6_in_valid", {31'b0, in_valid}, 32'd0);
      check("s6_inst", inst, 32'd0);
      check("s6_busy", {31'b0, busy}, 32'd0);
      check_flags("s6_rst", 1'b0, 1'b0, 2'd0);
      check("s6_issued", issued_cnt, 32'd0);
      check("s6_cycle", cycle_cnt, 32'd0);
      do_start(1);
      check("s6_restart_inst", inst, 32'hA);
      respond(32'd4, 1);
      check_flags("s6", 1'b1, 1'b0, 2'd0);
      check("s6_issued_end", issued_cnt, 32'd1);

      // ROM write in the start cycle is seen by the first issue
      do_reset();
      load_en   = 1'b1;
      load_addr = '0;
      load_data = 32'h55;
      model_rom[0] = 32'h55;
      do_start(1);
      load_en = 1'b0;
      check("s7_bypass_inst", inst, 32'h55);
      respond(32'd4, 1);
      check_flags("s7", 1'b1, 1'b0, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
